// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

   // Default count/load width in bits.
   localparam int TIMER_WIDTH = 16;

   // FSM state, 3-bit encoding.
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_LOADED  = 3'd1;
   localparam state_t ST_RUN     = 3'd2;
   localparam state_t ST_PAUSE   = 3'd3;
   localparam state_t ST_EXPIRED = 3'd4;

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector: rise is high while in is high and was low last cycle.
// Latency: rise is combinational from in; history register updates every edge.
// Backpressure: none; runs every cycle regardless of downstream state.
module tick_edge_detect (
   input  logic clk,
   input  logic rst_b,
   input  logic in,
   output logic rise
);

   logic prev;

   // Remember the previous-cycle level so a held-high input fires once.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         prev <= 1'b0;
      end else begin
         prev <= in;
      end
   end

   assign rise = in & ~prev;

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer driven by an external tick time base; TIMER_AUTORELOAD_EN enables periodic reload on expiry.
// Latency: a tick edge sampled in RUN updates count, done and expired on that same clock edge.
// Backpressure: none; control inputs act in priority order clear > load > stop > start > tick every cycle.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int WIDTH = TIMER_WIDTH
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             tick,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             done,
   output logic             expired
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   logic [WIDTH-1:0] reload;
   logic             tick_rise;
   logic             start_ok;

   // Edge detection runs in every state, so entering RUN with tick held high does not count.
   tick_edge_detect u_tick_edge (
      .clk   (clk),
      .rst_b (rst_b),
      .in    (tick),
      .rise  (tick_rise)
   );

   // start only has an effect from LOADED or PAUSE.
   assign start_ok = start && ((state == ST_LOADED) || (state == ST_PAUSE));

   assign running = (state == ST_RUN);

   // Main FSM and counter; done defaults low so it is a single-cycle pulse.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state   <= ST_IDLE;
         count   <= '0;
         reload  <= '0;
         done    <= 1'b0;
         expired <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clear) begin
            state   <= ST_IDLE;
            count   <= '0;
            expired <= 1'b0;
         end else if (load) begin
            state   <= ST_LOADED;
            count   <= load_val;
            reload  <= load_val;
            expired <= 1'b0;
         end else if (stop) begin
            // stop outranks start; it only changes state when running.
            if (state == ST_RUN) begin
               state <= ST_PAUSE;
            end
         end else if (start_ok) begin
            if (count == '0) begin
               // Nothing to count: expire immediately.
               state   <= ST_EXPIRED;
               done    <= 1'b1;
               expired <= 1'b1;
            end else begin
               state <= ST_RUN;
            end
         end else if (tick_rise && (state == ST_RUN)) begin
            if (count > ONE) begin
               count <= count - ONE;
            end else begin
               // Expiry edge (count 1 -> 0); a zero count here never wraps.
               done    <= 1'b1;
               expired <= 1'b1;
`ifdef TIMER_AUTORELOAD_EN
               if (reload != '0) begin
                  count <= reload;
               end else begin
                  count <= '0;
                  state <= ST_EXPIRED;
               end
`else
               count <= '0;
               state <= ST_EXPIRED;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus randomized stimulus vs a reference model.
// Latency: outputs sampled 1 time unit after each rising clk edge.
// Backpressure: n/a.
module tb_countdown_timer;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_b;
   logic         tick, load, start, stop, clear;
   logic [W-1:0] load_val;
   logic [W-1:0] count;
   logic         running, done, expired;

   int checks = 0;
   int errors = 0;

   countdown_timer #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .tick     (tick),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .stop     (stop),
      .clear    (clear),
      .count    (count),
      .running  (running),
      .done     (done),
      .expired  (expired)
   );

   always #5 clk = ~clk;

   // Reference model: timer phases described by the behavioural rules.
   localparam int M_IDLE = 0, M_ARMED = 1, M_COUNTING = 2, M_HELD = 3, M_FINISHED = 4;
   int           m_phase;
   logic [W-1:0] m_count, m_reload;
   logic         m_done, m_expired, m_last_tick;

   task automatic model_edge();
      logic ev;
      ev = tick && !m_last_tick;
      m_done = 1'b0;
      if (!rst_b) begin
         m_phase = M_IDLE; m_count = '0; m_reload = '0;
         m_expired = 1'b0; m_last_tick = 1'b0;
         return;
      end
      m_last_tick = tick;
      if (clear) begin
         m_phase = M_IDLE; m_count = '0; m_expired = 1'b0;
      end else if (load) begin
         m_phase = M_ARMED; m_count = load_val; m_reload = load_val; m_expired = 1'b0;
      end else if (stop) begin
         if (m_phase == M_COUNTING) m_phase = M_HELD;
      end else if (start && (m_phase == M_ARMED || m_phase == M_HELD)) begin
         if (m_count == 0) begin
            m_phase = M_FINISHED; m_done = 1'b1; m_expired = 1'b1;
         end else begin
            m_phase = M_COUNTING;
         end
      end else if (ev && m_phase == M_COUNTING) begin
         if (m_count > 1) begin
            m_count = m_count - 16'd1;
         end else begin
            m_done = 1'b1; m_expired = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
            if (m_reload != 0) m_count = m_reload;
            else begin m_count = '0; m_phase = M_FINISHED; end
`else
            m_count = '0; m_phase = M_FINISHED;
`endif
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      tick = 0; load = 0; start = 0; stop = 0; clear = 0; load_val = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_b = 1'b0;
      step();
      rst_b = 1'b1;
   endtask

   task automatic pulse_tick();
      tick = 1'b1; step(); tick = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      tick = 1; load = 1; load_val = 16'd55; start = 1;
      rst_b = 1'b0;
      step();
      rst_b = 1'b1;
      idle_inputs();
      checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (expired !== 1'b0) begin errors++; $display("FAIL reset_expired got %b exp 0", expired); end
   endtask

   task automatic test_basic();
      logic [W-1:0] exp_cnt;
      do_reset();
      load_val = 16'd3; load = 1; step(); load = 0;
      checks++; if (count !== 16'd3) begin errors++; $display("FAIL basic_load got %0d exp 3", count); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL basic_loaded_run got %b exp 0", running); end
      start = 1; step(); start = 0;
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL basic_start got %b exp 1", running); end
      for (int i = 0; i < 3; i++) begin
         pulse_tick();
         exp_cnt = 16'd2 - 16'(i);
`ifdef TIMER_AUTORELOAD_EN
         if (i == 2) exp_cnt = 16'd3;
`endif
         checks++; if (count !== exp_cnt) begin errors++; $display("FAIL basic_count tick %0d got %0d exp %0d", i, count, exp_cnt); end
         checks++; if (done !== (i == 2)) begin errors++; $display("FAIL basic_done tick %0d got %b exp %b", i, done, (i == 2)); end
         step();
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width tick %0d got %b exp 0", i, done); end
         repeat (3) step();
      end
      checks++; if (expired !== 1'b1) begin errors++; $display("FAIL basic_expired got %b exp 1", expired); end
`ifdef TIMER_AUTORELOAD_EN
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL basic_running got %b exp 1", running); end
`else
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL basic_running got %b exp 0", running); end
`endif
   endtask

   task automatic test_pause();
      do_reset();
      load_val = 16'd5; load = 1; step(); load = 0;
      start = 1; step(); start = 0;
      repeat (2) begin pulse_tick(); step(); end
      stop = 1; step(); stop = 0;
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got %b exp 0", running); end
      for (int i = 0; i < 4; i++) begin
         pulse_tick(); step();
         checks++; if (count !== 16'd3) begin errors++; $display("FAIL pause_hold tick %0d got %0d exp 3", i, count); end
      end
      start = 1; step(); start = 0;
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_resume got %b exp 1", running); end
      repeat (3) begin pulse_tick(); step(); end
`ifdef TIMER_AUTORELOAD_EN
      checks++; if (count !== 16'd5) begin errors++; $display("FAIL pause_end_count got %0d exp 5", count); end
`else
      checks++; if (count !== 16'd0) begin errors++; $display("FAIL pause_end_count got %0d exp 0", count); end
`endif
      checks++; if (expired !== 1'b1) begin errors++; $display("FAIL pause_expired got %b exp 1", expired); end
   endtask

   task automatic test_hold();
      do_reset();
      load_val = 16'd4; load = 1; step(); load = 0;
      start = 1; step(); start = 0;
      tick = 1; repeat (10) step(); tick = 0; step();
      checks++; if (count !== 16'd3) begin errors++; $display("FAIL hold_count got %0d exp 3", count); end
      // Entering RUN while tick is already high must not count.
      load_val = 16'd6; load = 1; step(); load = 0;
      tick = 1; step();
      start = 1; step(); start = 0;
      repeat (3) step();
      tick = 0; step();
      checks++; if (count !== 16'd6) begin errors++; $display("FAIL hold_enter_high got %0d exp 6", count); end
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL hold_enter_run got %b exp 1", running); end
   endtask

   task automatic test_priority();
      do_reset();
      load_val = 16'd7; load = 1; step(); load = 0;
      start = 1; step(); start = 0;
      load_val = 16'd11; clear = 1; load = 1; start = 1; tick = 1; step();
      idle_inputs();
      checks++; if (count !== 16'd0) begin errors++; $display("FAIL prio_clear_count got %0d exp 0", count); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL prio_clear_run got %b exp 0", running); end
      start = 1; step(); start = 0;
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL prio_idle_start got %b exp 0", running); end
      load_val = 16'd12; load = 1; step(); load = 0;
      start = 1; step(); start = 0;
      load_val = 16'd9; load = 1; stop = 1; step();
      idle_inputs();
      checks++; if (count !== 16'd9) begin errors++; $display("FAIL prio_load_count got %0d exp 9", count); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL prio_load_run got %b exp 0", running); end
      start = 1; step(); start = 0;
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL prio_loaded_start got %b exp 1", running); end
   endtask

   task automatic test_zero();
      do_reset();
      load_val = 16'd0; load = 1; step(); load = 0;
      start = 1; step(); start = 0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done); end
      checks++; if (expired !== 1'b1) begin errors++; $display("FAIL zero_expired got %b exp 1", expired); end
      checks++; if (count !== 16'd0) begin errors++; $display("FAIL zero_count got %0d exp 0", count); end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL zero_running got %b exp 0", running); end
      pulse_tick(); step();
      checks++; if (count !== 16'd0) begin errors++; $display("FAIL zero_nowrap got %0d exp 0", count); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b exp 0", done); end
      start = 1; step(); start = 0;
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL zero_exp_start got %b exp 0", running); end
`ifdef TIMER_AUTORELOAD_EN
      load_val = 16'd2; load = 1; step(); load = 0;
      start = 1; step(); start = 0;
      for (int k = 1; k <= 6; k++) begin
         pulse_tick();
         checks++; if (done !== ((k % 2) == 0)) begin errors++; $display("FAIL autoreload_done tick %0d got %b", k, done); end
         checks++; if (running !== 1'b1) begin errors++; $display("FAIL autoreload_run tick %0d got %b exp 1", k, running); end
         step();
      end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      load_val = 16'd4; load = 1; step(); load = 0;
      start = 1; step(); start = 0;
      repeat (2) begin pulse_tick(); step(); end
      checks++; if (count !== 16'd2) begin errors++; $display("FAIL rmid_pre got %0d exp 2", count); end
      rst_b = 1'b0; step(); rst_b = 1'b1;
      checks++; if ({count, running, done, expired} !== '0) begin errors++; $display("FAIL rmid_outputs got cnt %0d run %b done %b exp %b, want all 0", count, running, done, expired); end
      for (int i = 0; i < 4; i++) begin
         if (i == 2) start = 1;
         pulse_tick(); start = 0; step();
         checks++; if (done !== 1'b0 || count !== 16'd0 || running !== 1'b0) begin errors++; $display("FAIL rmid_after %0d got cnt %0d run %b done %b, want 0", i, count, running, done); end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rst_b    = ($urandom_range(0, 99) >= 2);
         clear    = ($urandom_range(0, 99) < 3);
         load     = ($urandom_range(0, 99) < 6);
         load_val = 16'($urandom_range(0, 6));
         stop     = ($urandom_range(0, 99) < 6);
         start    = ($urandom_range(0, 99) < 15);
         tick     = ($urandom_range(0, 99) < 45);
         step();
         checks++; if (count !== m_count) begin errors++; $display("FAIL rnd_count cycle %0d got %0d exp %0d", c, count, m_count); end
         checks++; if (running !== (m_phase == M_COUNTING)) begin errors++; $display("FAIL rnd_running cycle %0d got %b exp %b", c, running, (m_phase == M_COUNTING)); end
         checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done cycle %0d got %b exp %b", c, done, m_done); end
         checks++; if (expired !== m_expired) begin errors++; $display("FAIL rnd_expired cycle %0d got %b exp %b", c, expired, m_expired); end
      end
      rst_b = 1'b1;
      idle_inputs();
   endtask

   initial begin
      rst_b = 1'b1;
      idle_inputs();
      m_phase = M_IDLE; m_count = '0; m_reload = '0;
      m_done = 1'b0; m_expired = 1'b0; m_last_tick = 1'b0;
      test_reset();
      test_basic();
      test_pause();
      test_hold();
      test_priority();
      test_zero();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
